// File: rtl/gray_ptr_sync_if.sv
// Bundle of signals around one Gray pointer crossing: source pointer and
// err_clr in, synchronised pointer views and status out.
interface gray_ptr_sync_if #(
   parameter int ADDR_WIDTH = 6
);
   localparam int W = ADDR_WIDTH + 1;

   logic [W-1:0] gray_in;
   logic         err_clr;
   logic [W-1:0] gray_out;
   logic [W-1:0] bin_out;
   logic [W-1:0] delta;
   logic         advanced;
   logic         sync_valid;
   logic         err;

   // No handshake: every output is a registered level, sampled every clock.
   modport master (
      output gray_in, err_clr,
      input  gray_out, bin_out, delta, advanced, sync_valid, err
   );

   modport slave (
      input  gray_in, err_clr,
      output gray_out, bin_out, delta, advanced, sync_valid, err
   );
endinterface

// File: rtl/gray_ptr_sync.sv
// Multi-stage synchroniser for a Gray-coded FIFO pointer, with registered
// binary conversion, per-cycle advance count, post-reset valid and sticky error.
module gray_ptr_sync #(
   parameter int ADDR_WIDTH = 6,
   parameter int STAGES     = 2,
   parameter int MAX_DELTA  = 1
) (
   input logic            clk,
   input logic            rst,
   gray_ptr_sync_if.slave bus
);
   localparam int           W        = ADDR_WIDTH + 1;
   localparam logic [W-1:0] MAX_D    = W'(MAX_DELTA);
   localparam logic [2:0]   FILL_MAX = 3'(STAGES + 1);
   localparam logic [2:0]   FILL_LST = 3'(STAGES);

   if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
      $error("gray_ptr_sync: STAGES must be in 2..4");
   end

   (* ASYNC_REG = "TRUE", keep = "true" *) logic [W-1:0] stage [STAGES];

   logic [W-1:0] bin_q;
   logic [W-1:0] delta_q;
   logic         adv_q;
   logic         valid_q;
   logic         err_q;
   logic [2:0]   fill_q;
   logic [W-1:0] b;
   logic [W-1:0] d;

   // Bare flop chain: nothing may sit between stages.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < STAGES; i++) stage[i] <= '0;
      end else begin
         stage[0] <= bus.gray_in;
         for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
      end
   end

   // Binary bit i is the XOR of Gray bits i..W-1.
   always_comb begin
      b = '0;
      for (int i = 0; i < W; i++) b[i] = ^(stage[STAGES-1] >> i);
      d = b - bin_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bin_q   <= '0;
         delta_q <= '0;
         adv_q   <= 1'b0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         fill_q  <= '0;
      end else begin
         bin_q <= b;
         if (fill_q != FILL_MAX) fill_q <= fill_q + 3'd1;
         if (fill_q == FILL_LST) valid_q <= 1'b1;
         // The first converted sample after reset has no meaningful predecessor.
         if (valid_q) begin
            delta_q <= d;
            adv_q   <= (d != '0);
         end else begin
            delta_q <= '0;
            adv_q   <= 1'b0;
         end
         if (valid_q && (d > MAX_D)) err_q <= 1'b1;
         else if (bus.err_clr)       err_q <= 1'b0;
      end
   end

   assign bus.gray_out   = stage[STAGES-1];
   assign bus.bin_out    = bin_q;
   assign bus.delta      = delta_q;
   assign bus.advanced   = adv_q;
   assign bus.sync_valid = valid_q;
   assign bus.err        = err_q;
endmodule

// File: tb/tb_gray_ptr_sync.sv
// Bench for gray_ptr_sync: STAGES=2 and STAGES=3 instances fed identical
// stimulus, each checked every cycle against a queue of driven pointers.
module tb_gray_ptr_sync;
   localparam int W     = 7;
   localparam int MAX_D = 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   gray_ptr_sync_if #(.ADDR_WIDTH(6)) ifa ();
   gray_ptr_sync_if #(.ADDR_WIDTH(6)) ifb ();

   gray_ptr_sync #(.ADDR_WIDTH(6), .STAGES(2), .MAX_DELTA(MAX_D)) dut_a (
      .clk(clk), .rst(rst), .bus(ifa)
   );
   gray_ptr_sync #(.ADDR_WIDTH(6), .STAGES(3), .MAX_DELTA(MAX_D)) dut_b (
      .clk(clk), .rst(rst), .bus(ifb)
   );

   logic [W-1:0] exp_a_q[$];
   logic [W-1:0] exp_b_q[$];
   logic [W-1:0] drv_gray;
   logic         drv_clr;
   logic [W-1:0] m_prev [2];
   int           m_fill [2];
   logic         m_valid[2];
   logic         m_err  [2];
   int           n_checks = 0;
   int           n_errors = 0;

   function automatic logic [W-1:0] gray(int n);
      logic [W-1:0] v;
      v = W'(n);
      return v ^ (v >> 1);
   endfunction

   function automatic logic [W-1:0] g2b(logic [W-1:0] g);
      logic [W-1:0] r;
      r = g;
      for (int s = 1; s < W; s++) r = r ^ (g >> s);
      return r;
   endfunction

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic set_in(logic [W-1:0] g, logic c);
      drv_gray    = g;
      drv_clr     = c;
      ifa.gray_in = g;
      ifa.err_clr = c;
      ifb.gray_in = g;
      ifb.err_clr = c;
   endtask

   task automatic model_reset();
      exp_a_q.delete();
      exp_b_q.delete();
      repeat (2) exp_a_q.push_back('0);
      repeat (3) exp_b_q.push_back('0);
      for (int i = 0; i < 2; i++) begin
         m_prev[i]  = '0;
         m_fill[i]  = 0;
         m_valid[i] = 1'b0;
         m_err[i]   = 1'b0;
      end
   endtask

   task automatic model_dut(int i, int s, string nm, logic [W-1:0] old_g,
                            logic [W-1:0] next_g, logic [W-1:0] g_o,
                            logic [W-1:0] b_o, logic [W-1:0] d_o,
                            logic adv_o, logic v_o, logic e_o);
      logic [W-1:0] eb, d, d_exp;
      logic         vb;
      eb    = g2b(old_g);
      d     = eb - m_prev[i];
      vb    = m_valid[i];
      d_exp = vb ? d : '0;
      if (vb && (d > W'(MAX_D))) m_err[i] = 1'b1;
      else if (drv_clr)          m_err[i] = 1'b0;
      if (m_fill[i] < s + 1) m_fill[i]++;
      m_valid[i] = (m_fill[i] == s + 1);
      m_prev[i]  = eb;
      check({nm, " gray_out"},   g_o,   next_g);
      check({nm, " bin_out"},    b_o,   eb);
      check({nm, " delta"},      d_o,   d_exp);
      check({nm, " advanced"},   adv_o, (d_exp != '0));
      check({nm, " sync_valid"}, v_o,   m_valid[i]);
      check({nm, " err"},        e_o,   m_err[i]);
   endtask

   // One clock: the pointer present at the edge enters each queue, and the
   // entry leaving the front is what bin_out must now show.
   task automatic tick();
      logic [W-1:0] pa, pb;
      @(posedge clk);
      #1;
      exp_a_q.push_back(drv_gray);
      exp_b_q.push_back(drv_gray);
      pa = exp_a_q.pop_front();
      pb = exp_b_q.pop_front();
      model_dut(0, 2, "a", pa, exp_a_q[0], ifa.gray_out, ifa.bin_out, ifa.delta,
                ifa.advanced, ifa.sync_valid, ifa.err);
      model_dut(1, 3, "b", pb, exp_b_q[0], ifb.gray_out, ifb.bin_out, ifb.delta,
                ifb.advanced, ifb.sync_valid, ifb.err);
   endtask

   task automatic check_idle(string tag);
      check({tag, " a gray_out"}, ifa.gray_out, 0);
      check({tag, " a bin_out"},  ifa.bin_out,  0);
      check({tag, " a delta"},    ifa.delta,    0);
      check({tag, " a flags"},    {ifa.advanced, ifa.sync_valid, ifa.err}, 0);
      check({tag, " b gray_out"}, ifb.gray_out, 0);
      check({tag, " b bin_out"},  ifb.bin_out,  0);
      check({tag, " b flags"},    {ifb.advanced, ifb.sync_valid, ifb.err}, 0);
   endtask

   // Reset asserted and released between edges; outputs must clear at once.
   task automatic pulse_reset();
      #2 rst = 1'b1;
      #1 check_idle("async rst");
      #2 rst = 1'b0;
      model_reset();
   endtask

   initial begin
      int n;
      logic c;
      set_in(7'h55, 1'b0);
      model_reset();
      #22 check_idle("rst held");
      @(negedge clk);
      rst = 1'b0;

      // Reset release and fill with a fixed pointer
      tick();
      tick();
      check("t1 a gray_out edge2", ifa.gray_out, 7'h55);
      tick();
      check("t1 a bin_out edge3", ifa.bin_out, 7'h66);
      check("t1 a valid edge3", ifa.sync_valid, 1'b1);
      check("t1 b valid edge3", ifb.sync_valid, 1'b0);
      tick();
      check("t1 b valid edge4", ifb.sync_valid, 1'b1);
      check("t1 b bin_out edge4", ifb.bin_out, 7'h66);

      // Held input
      repeat (10) begin
         tick();
         check("t5 a bin_out hold", ifa.bin_out, 7'h66);
      end

      // Streaming increment through the wrap, with a reset mid-stream
      set_in(gray(0), 1'b0);
      tick();
      pulse_reset();
      repeat (5) tick();
      for (int k = 1; k <= 131; k++) begin
         set_in(gray(k % 128), 1'b0);
         tick();
         if (k == 10) pulse_reset();
      end
      repeat (6) tick();

      // Over-advance, clear, and set-beats-clear
      set_in(gray(5), 1'b0);
      tick();
      pulse_reset();
      repeat (6) tick();
      set_in(gray(9), 1'b0);
      tick();
      tick();
      tick();
      check("t4 a delta jump", ifa.delta, 4);
      check("t4 a advanced jump", ifa.advanced, 1'b1);
      check("t4 a err jump", ifa.err, 1'b1);
      repeat (4) tick();
      check("t4 b err held", ifb.err, 1'b1);
      set_in(gray(9), 1'b1);
      tick();
      set_in(gray(9), 1'b0);
      check("t4 a err cleared", ifa.err, 1'b0);
      check("t4 b err cleared", ifb.err, 1'b0);
      set_in(gray(13), 1'b1);
      tick();
      tick();
      tick();
      check("t4 a set beats clr", ifa.err, 1'b1);
      tick();
      check("t4 b set beats clr", ifb.err, 1'b1);
      tick();
      tick();
      set_in(gray(13), 1'b0);
      repeat (3) tick();

      // Random steps of 0..2 with occasional err_clr pulses
      n = 13;
      repeat (80) begin
         n = n + int'($urandom_range(0, 2));
         c = ($urandom_range(0, 7) == 0);
         set_in(gray(n % 128), c);
         tick();
      end
      set_in(gray(n % 128), 1'b0);
      repeat (6) tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/gray_ptr_sync.md
Name: gray_ptr_sync

Overview:
- Parametrised multi-stage synchroniser for Gray-coded FIFO pointers arriving from a foreign clock domain. It succeeds the fixed-depth pointer synchroniser.
- Adds configurable stage count, registered Gray-to-binary conversion, a per-cycle advance count, a post-reset valid flag and a sticky over-advance error flag.
- Instanced once per crossing pointer: write pointer into the read domain, and read pointer into the write domain.

Parameters:
ADDR_WIDTH, 6, FIFO address width; pointer width W = ADDR_WIDTH+1
STAGES, 2, synchroniser flop count, legal 2..4 (elaboration error otherwise)
MAX_DELTA, 1, largest legal pointer advance per destination clock; larger advances set err

Ports:
clk  in  1  destination-domain clock
rst  in  1  asynchronous, active-high reset
gray_in  in  W  Gray pointer from source domain, asynchronous to clk
err_clr  in  1  synchronous clear of sticky err
gray_out  out  W  synchronised Gray pointer (last synchroniser stage)
bin_out  out  W  registered binary equivalent of gray_out
delta  out  W  bin_out advance since previous cycle, modulo 2^W
advanced  out  1  registered (delta != 0)
sync_valid  out  1  chain flushed since reset; downstream ignores other outputs while low
err  out  1  sticky: an advance exceeded MAX_DELTA

Behaviour:
- Reset: rst is asynchronous and active-high. While it is high, all stages, gray_out, bin_out, delta, advanced, sync_valid, err and the fill counter are 0. Assertion mid-operation clears all of them immediately, without waiting for an edge.
- Synchroniser chain: stage[0] <= gray_in; stage[i] <= stage[i-1]; gray_out = stage[STAGES-1].
  - Latency from gray_in to gray_out is STAGES edges.
  - No logic between stages. Stages carry the synthesis keep/async-reg attribute.
- Conversion, evaluated every edge:
  - b = g2b(gray_out), where b[W-1] = g[W-1] and b[i] = b[i+1] ^ g[i].
  - bin_out <= b, so latency from gray_in to bin_out is STAGES+1.
- Advance count: d = (b - bin_out) mod 2^W, computed on the old bin_out.
  - If sync_valid was 1 before the edge: delta <= d and advanced <= (d != 0).
  - Otherwise delta <= 0 and advanced <= 0.
  - Wrap from 2^W-1 to 0 yields d = 1.
  - A backward step (source pointer reset) yields a large d, which is reported, not corrected.
- Fill counter: counts edges after rst deasserts, saturating at STAGES+1. sync_valid <= 1 on edge STAGES+1 and stays 1 until the next reset.
- Error: on an edge where sync_valid was already 1 and d > MAX_DELTA (unsigned), err <= 1. err_clr clears err on the next edge.
  - Set beats clear when both happen on the same edge.
  - err_clr has no effect on any other output.
- Stable input: if gray_in is held, outputs settle by edge STAGES+2 with delta = 0 and advanced = 0.
- No handshake; all outputs are registered. gray_in may change at any time relative to clk.

Test Plan:
1. Reset and fill (STAGES=2, W=7): rst high, gray_in=0x55 -> all outputs 0. After release:
   - gray_out=0x55 at edge 2.
   - bin_out=0x66 and sync_valid=1 at edge 3.
   - delta=0, advanced=0, err=0 throughout (first sample is suppressed).
2. Streaming increment: after valid, drive gray(n) for n=0..20, one per clock -> bin_out follows n with 3-edge lag; delta=1, advanced=1 every cycle; err=0. Repeat with STAGES=3 -> 4-edge lag, sync_valid at edge 4.
3. Wrap-around: step gray_in gray(126)=0x41 -> gray(127)=0x40 -> gray(0)=0x00 -> bin_out 126, 127, 0 with delta=1 each cycle; err=0.
4. Over-advance: MAX_DELTA=1, jump gray(5)=0x07 to gray(9)=0x0D -> delta=4, advanced=1, err=1 the same cycle. err stays high while input is held. Then:
   - err_clr pulse -> err=0 next edge.
   - Repeat the jump with err_clr asserted on the violating edge -> err=1.
5. Hold: gray_in constant for 10 clocks after valid -> delta=0, advanced=0, gray_out/bin_out constant.
6. Reset mid-stream: during test 2, assert rst between edges -> all outputs 0 with no clock edge. After release, sync_valid returns on edge STAGES+1, with no spurious err or delta on the refill.
